pwm_ventilador: RTL and testbench



---
 rtl/pwm_ventilador_pkg.sv | 20 ++
 rtl/pwm_contador_periodo.sv | 56 +++++
 rtl/pwm_ventilador.sv | 142 ++++++++++++++
 tb/tb_pwm_ventilador.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ventilador_pkg.sv
// ---------------------------------------------------------------------------
// pwm_ventilador_pkg
// Shared definitions for the fan PWM block and the temperature register:
//   TEMP_W    - width of the temperature code / duty level (3 bits)
//   NIVEL_MAX - highest duty level (7 => constant high)
//   estado_t  - ramp state machine encoding
// ---------------------------------------------------------------------------
package pwm_ventilador_pkg;

   localparam int unsigned TEMP_W    = 3;
   localparam int unsigned NIVEL_MAX = 7;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SUBIENDO = 2'd1,
      BAJANDO  = 2'd2,
      ARRANQUE = 2'd3
   } estado_t;

endpackage

// File: rtl/pwm_contador_periodo.sv
// ---------------------------------------------------------------------------
// pwm_contador_periodo
// PWM period counter (0 .. 7*STEP-1), end-of-period pulse and the registered
// duty compare.
// Ports:
//   clk         - system clock
//   reset       - synchronous, active-high
//   nivel_sig   - duty level that will be held in the next cycle
//   forzar      - force the output high in the next cycle (spin-up kick)
//   pwm_out     - registered PWM output, aligned to the counter
//   fin_periodo - high in the last cycle of every period
// ---------------------------------------------------------------------------
module pwm_contador_periodo
   import pwm_ventilador_pkg::*;
#(
   parameter int unsigned STEP = 16
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [TEMP_W-1:0] nivel_sig,
   input  logic              forzar,
   output logic              pwm_out,
   output logic              fin_periodo
);

   localparam int unsigned PERIODO = NIVEL_MAX * STEP;
   // 7*STEP is never a power of two, so 7*STEP itself also fits in CW bits
   // and nivel*STEP never truncates.
   localparam int unsigned CW      = $clog2(PERIODO);
   localparam logic [CW-1:0] CNT_ULT = CW'(PERIODO - 1);
   localparam logic [CW-1:0] STEP_C  = CW'(STEP);

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_sig;
   logic [CW-1:0] umbral;

   always_comb begin
      cnt_sig = (cnt == CNT_ULT) ? '0 : cnt + 1'b1;
      umbral  = CW'(nivel_sig) * STEP_C;
   end

   assign fin_periodo = (cnt == CNT_ULT);

   // Compare against next-state count and level so the registered output
   // lines up with the cycle that holds that count.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= '0;
         pwm_out <= 1'b0;
      end else begin
         cnt     <= cnt_sig;
         pwm_out <= forzar | (cnt_sig < umbral);
      end
   end

endmodule

// File: rtl/pwm_ventilador.sv
// ---------------------------------------------------------------------------
// pwm_ventilador
// Converts the 3-bit temperature code into a fan PWM whose duty level ramps
// one step at a time toward the latched target, every RAMP_PERIODS periods.
// Optional macro PWM_VENTILADOR_KICKSTART_EN: adds a full-duty spin-up phase
// (ARRANQUE, KICK_PERIODS periods) when starting from level 0.
// Ports:
//   clk         - system clock
//   reset       - synchronous, active-high
//   temp        - temperature code, sampled only at period boundaries
//   pwm_out     - registered fan PWM
//   nivel       - duty level currently applied
//   objetivo    - target level latched from temp
//   fin_periodo - pulse in the last cycle of each PWM period
//   rampa       - high while nivel differs from objetivo (or during kick)
// ---------------------------------------------------------------------------
module pwm_ventilador
   import pwm_ventilador_pkg::*;
#(
   parameter int unsigned STEP         = 16,
   parameter int unsigned RAMP_PERIODS = 4
`ifdef PWM_VENTILADOR_KICKSTART_EN
   ,parameter int unsigned KICK_PERIODS = 8
`endif
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [TEMP_W-1:0] temp,
   output logic              pwm_out,
   output logic [TEMP_W-1:0] nivel,
   output logic [TEMP_W-1:0] objetivo,
   output logic              fin_periodo,
   output logic              rampa
);

   localparam int unsigned RW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
   localparam logic [RW-1:0] RAMP_ULT = RW'(RAMP_PERIODS - 1);

   estado_t           estado, estado_sig;
   logic [RW-1:0]     rc, rc_sig;
   logic [TEMP_W-1:0] nivel_sig, objetivo_sig;
   logic              paso;
   logic              en_arranque;
   logic              forzar;

`ifdef PWM_VENTILADOR_KICKSTART_EN
   localparam int unsigned KW = (KICK_PERIODS > 1) ? $clog2(KICK_PERIODS) : 1;
   localparam logic [KW-1:0] KICK_ULT = KW'(KICK_PERIODS - 1);
   logic [KW-1:0] kc, kc_sig;
`endif

   always_comb begin
      objetivo_sig = objetivo;
      nivel_sig    = nivel;
      rc_sig       = rc;
      estado_sig   = estado;
      paso         = 1'b0;
      en_arranque  = 1'b0;
`ifdef PWM_VENTILADOR_KICKSTART_EN
      kc_sig       = kc;
`endif
      if (fin_periodo) begin
         objetivo_sig = temp;
         if (rc == RAMP_ULT) begin
            rc_sig = '0;
            paso   = 1'b1;
         end else begin
            rc_sig = rc + 1'b1;
         end
         // The step uses the target latched on this same edge.
         if (paso) begin
            if (nivel < objetivo_sig)
               nivel_sig = nivel + 1'b1;
            else if (nivel > objetivo_sig)
               nivel_sig = nivel - 1'b1;
         end
`ifdef PWM_VENTILADOR_KICKSTART_EN
         // Kick overrides the normal ramp: level pinned at 0, ramp timer held.
         if (estado == ARRANQUE) begin
            rc_sig    = '0;
            nivel_sig = '0;
            if (objetivo_sig == '0) begin
               // abort: level 0 == target falls through to IDLE below
            end else if (kc == KICK_ULT) begin
               nivel_sig = TEMP_W'(1);
            end else begin
               kc_sig      = kc + 1'b1;
               en_arranque = 1'b1;
            end
         end else if (nivel == '0 && objetivo_sig != '0) begin
            rc_sig      = '0;
            nivel_sig   = '0;
            kc_sig      = '0;
            en_arranque = 1'b1;
         end
`endif
         if (en_arranque)
            estado_sig = ARRANQUE;
         else if (nivel_sig < objetivo_sig)
            estado_sig = SUBIENDO;
         else if (nivel_sig > objetivo_sig)
            estado_sig = BAJANDO;
         else
            estado_sig = IDLE;
      end
      forzar = (estado_sig == ARRANQUE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         estado   <= IDLE;
         rc       <= '0;
         nivel    <= '0;
         objetivo <= '0;
`ifdef PWM_VENTILADOR_KICKSTART_EN
         kc       <= '0;
`endif
      end else begin
         estado   <= estado_sig;
         rc       <= rc_sig;
         nivel    <= nivel_sig;
         objetivo <= objetivo_sig;
`ifdef PWM_VENTILADOR_KICKSTART_EN
         kc       <= kc_sig;
`endif
      end
   end

   assign rampa = (estado != IDLE);

   pwm_contador_periodo #(
      .STEP (STEP)
   ) u_contador (
      .clk         (clk),
      .reset       (reset),
      .nivel_sig   (nivel_sig),
      .forzar      (forzar),
      .pwm_out     (pwm_out),
      .fin_periodo (fin_periodo)
   );

endmodule

// File: tb/tb_pwm_ventilador.sv
`timescale 1ns/1ps
module tb_pwm_ventilador;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] temp;
   logic       pwm_out;
   logic [2:0] nivel;
   logic [2:0] objetivo;
   logic       fin_periodo;
   logic       rampa;

   int checks = 0;
   int errors = 0;
   int altos, forma, inestable, ciclos;

   always #5 clk = ~clk;

   pwm_ventilador #(
      .STEP         (4),
      .RAMP_PERIODS (2)
`ifdef PWM_VENTILADOR_KICKSTART_EN
      ,.KICK_PERIODS (2)
`endif
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .temp        (temp),
      .pwm_out     (pwm_out),
      .nivel       (nivel),
      .objetivo    (objetivo),
      .fin_periodo (fin_periodo),
      .rampa       (rampa)
   );

   task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      checks++;
      if (obs !== esp) begin
         errors++;
         $display("FAIL %s: obtenido %0d esperado %0d", tag, obs, esp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advance to the last cycle of the current period (bounded).
   task automatic ir_a_fin();
      for (int i = 0; i < 40 && fin_periodo !== 1'b1; i++) tick();
      comprobar("fin_alcanzado", fin_periodo, 1);
   endtask

   // Cross the next boundary edge with temp = t; ends in the cycle holding cnt=0.
   task automatic frontera(input logic [2:0] t);
      ir_a_fin();
      temp = t;
      tick();
   endtask

   // Sample one full period from cnt=0; ends in the cycle holding cnt=27.
   task automatic medir(input int umbral, output int n_altos, output int n_forma);
      n_altos = 0;
      n_forma = 0;
      for (int k = 0; k < 28; k++) begin
         if (pwm_out === 1'b1) n_altos++;
         if (pwm_out !== logic'(k < umbral)) n_forma++;
         if (k < 27) tick();
      end
   endtask

   // Reset held for 5 cycles with temp=5, then released with temp=t.
   task automatic reset_inicial(input logic [2:0] t);
      reset = 1'b1;
      temp  = 3'd5;
      for (int i = 0; i < 5; i++) begin
         tick();
         comprobar("rst_pwm", pwm_out, 0);
         comprobar("rst_nivel", nivel, 0);
         comprobar("rst_objetivo", objetivo, 0);
         comprobar("rst_rampa", rampa, 0);
         comprobar("rst_fin", fin_periodo, 0);
      end
      temp  = t;
      reset = 1'b0;
      ciclos = 1;
      for (int i = 0; i < 40 && fin_periodo !== 1'b1; i++) begin
         tick();
         ciclos++;
      end
      comprobar("primer_fin_ciclo", ciclos, 28);
      comprobar("obj_antes_b1", objetivo, 0);
   endtask

`ifdef PWM_VENTILADOR_KICKSTART_EN
   int kick_niv[6] = '{1, 2, 2, 3, 3, 4};

   initial begin
      reset_inicial(3'd4);
      tick();                                  // B1
      comprobar("k_b1_obj", objetivo, 4);
      comprobar("k_b1_nivel", nivel, 0);
      comprobar("k_b1_rampa", rampa, 1);
      medir(28, altos, forma);
      comprobar("k_p1_altos", altos, 28);
      frontera(3'd4);                          // B2
      comprobar("k_b2_nivel", nivel, 0);
      comprobar("k_b2_rampa", rampa, 1);
      medir(28, altos, forma);
      comprobar("k_p2_altos", altos, 28);
      frontera(3'd4);                          // B3: kick ends
      comprobar("k_b3_nivel", nivel, 1);
      medir(4, altos, forma);
      comprobar("k_p3_altos", altos, 4);
      comprobar("k_p3_forma", forma, 0);
      for (int i = 0; i < 6; i++) begin        // B4..B9
         frontera(3'd4);
         comprobar("k_rampa_nivel", nivel, kick_niv[i]);
      end
      comprobar("k_fin_rampa", rampa, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
`else
   int sub3[5]  = '{1, 1, 2, 2, 3};
   int sub7[7]  = '{4, 4, 5, 5, 6, 6, 7};
   int baja2[9] = '{6, 6, 5, 5, 4, 4, 3, 3, 2};

   initial begin
      reset_inicial(3'd3);
      tick();                                  // B1
      comprobar("b1_obj", objetivo, 3);
      comprobar("b1_nivel", nivel, 0);
      comprobar("b1_rampa", rampa, 1);
      for (int i = 0; i < 5; i++) begin        // B2..B6
         frontera(3'd3);
         comprobar("sube3_nivel", nivel, sub3[i]);
         comprobar("sube3_rampa", rampa, (i == 4) ? 0 : 1);
      end
      medir(12, altos, forma);
      comprobar("duty3_altos", altos, 12);
      comprobar("duty3_forma", forma, 0);

      frontera(3'd7);                          // B7
      comprobar("b7_obj", objetivo, 7);
      comprobar("b7_nivel", nivel, 3);
      comprobar("b7_rampa", rampa, 1);
      for (int i = 0; i < 7; i++) begin        // B8..B14
         frontera(3'd7);
         comprobar("sube7_nivel", nivel, sub7[i]);
      end
      comprobar("nivel7_rampa", rampa, 0);
      medir(28, altos, forma);
      comprobar("duty7_altos", altos, 28);

      frontera(3'd2);                          // B15
      comprobar("b15_obj", objetivo, 2);
      comprobar("b15_nivel", nivel, 7);
      comprobar("b15_rampa", rampa, 1);
      for (int i = 0; i < 9; i++) begin        // B16..B24
         frontera(3'd2);
         comprobar("baja2_nivel", nivel, baja2[i]);
         comprobar("baja2_rampa", rampa, (baja2[i] == 2) ? 0 : 1);
      end

      // temp toggles inside one period; only the boundary value counts
      altos = 0;
      forma = 0;
      inestable = 0;
      for (int k = 0; k < 28; k++) begin
         if (pwm_out === 1'b1) altos++;
         if (pwm_out !== logic'(k < 8)) forma++;
         if (nivel !== 3'd2 || objetivo !== 3'd2) inestable++;
         if (k == 5)  temp = 3'd3;
         if (k == 10) temp = 3'd6;
         if (k == 15) temp = 3'd3;
         if (k < 27) tick();
      end
      comprobar("toggle_altos", altos, 8);
      comprobar("toggle_forma", forma, 0);
      comprobar("toggle_estable", inestable, 0);
      tick();                                  // B25
      comprobar("b25_obj", objetivo, 3);
      comprobar("b25_nivel", nivel, 2);

      frontera(3'd7);                          // B26
      comprobar("b26_nivel", nivel, 3);
      frontera(3'd7);                          // B27
      frontera(3'd7);                          // B28
      comprobar("b28_nivel", nivel, 4);
      for (int i = 0; i < 10; i++) tick();
      reset = 1'b1;
      tick();
      comprobar("rst1_pwm", pwm_out, 0);
      comprobar("rst1_nivel", nivel, 0);
      comprobar("rst1_obj", objetivo, 0);
      comprobar("rst1_rampa", rampa, 0);
      comprobar("rst1_fin", fin_periodo, 0);
      reset = 1'b0;
      ciclos = 1;
      for (int i = 0; i < 40 && fin_periodo !== 1'b1; i++) begin
         tick();
         ciclos++;
      end
      comprobar("rst1_cnt0", ciclos, 28);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
`endif

endmodule
